// File: rtl/tx_fifo_param.sv
// tx_fifo_param: synchronous FIFO with registered read data, status flags, sticky errors and optional peak occupancy tracking
// Ports: clk, reset (sync, active-high), init (active-low soft clear), wr_enable/data_in write side,
//        rd_enable read side, data_out/valid_out registered read data, umbral_af/umbral_ae thresholds,
//        full/empty/almost_full/almost_empty flags, overflow_err/underflow_err sticky errors,
//        cnt_out occupancy, peak_cnt high-water mark (tracked only when FIFO_PEAK_TRACK_EN is defined).
module tx_fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  wr_enable,
    input  logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   umbral_af,
    input  logic [ADDR_WIDTH:0]   umbral_ae,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic [ADDR_WIDTH:0]   cnt_out,
    output logic [ADDR_WIDTH:0]   peak_cnt
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_q, ovf_q, udf_q;
    logic                  clear, rd_acc, wr_acc;
    assign clear             = reset | ~init;
    assign full_fifo         = cnt_q == FULL_CNT;
    assign empty_fifo        = cnt_q == '0;
    assign almost_full_fifo  = cnt_q >= umbral_af;
    assign almost_empty_fifo = cnt_q <= umbral_ae;
    assign cnt_out           = cnt_q;
    assign data_out          = data_out_q;
    assign valid_out         = valid_q;
    assign overflow_err      = ovf_q;
    assign underflow_err     = udf_q;
    always_comb begin
        rd_acc = rd_enable & ~empty_fifo;
        // a read in the same cycle frees the slot, so a write on full is still accepted
        wr_acc = wr_enable & (~full_fifo | rd_acc);
        cnt_d  = (wr_acc & ~rd_acc) ? cnt_q + 1'b1 :
                 (rd_acc & ~wr_acc) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_acc) mem_q[wr_ptr_q] <= data_in;
            wr_ptr_q   <= wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q   <= rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
            cnt_q      <= cnt_d;
            data_out_q <= rd_acc ? mem_q[rd_ptr_q] : '0;
            valid_q    <= rd_acc;
            ovf_q      <= ovf_q | (wr_enable & full_fifo & ~rd_acc);
            udf_q      <= udf_q | (rd_enable & empty_fifo);
        end
    end
`ifdef FIFO_PEAK_TRACK_EN
    logic [ADDR_WIDTH:0] peak_q;
    always_ff @(posedge clk) begin
        if (clear) peak_q <= '0;
        else peak_q <= (cnt_d > peak_q) ? cnt_d : peak_q;
    end
    assign peak_cnt = peak_q;
`else
    assign peak_cnt = '0;
`endif
endmodule

// File: tb/tb_tx_fifo_param.sv
// tb_tx_fifo_param: randomized and directed checks of tx_fifo_param against a queue-based model
module tb_tx_fifo_param;
    logic       clk = 1'b0;
    logic       reset, init, wr_enable, rd_enable;
    logic [5:0] data_in;
    logic [2:0] umbral_af, umbral_ae;
    logic [5:0] data_out;
    logic       valid_out, full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo;
    logic       overflow_err, underflow_err;
    logic [2:0] cnt_out, peak_cnt;
    int errors = 0;
    int checks = 0;
    logic [5:0] q[$];
    logic [5:0] m_data;
    logic       m_valid, m_ovf, m_udf;
    int         m_peak;
`ifdef FIFO_PEAK_TRACK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif
    always #5 clk = ~clk;
    tx_fifo_param dut (
        .clk(clk), .reset(reset), .init(init), .wr_enable(wr_enable), .rd_enable(rd_enable),
        .data_in(data_in), .umbral_af(umbral_af), .umbral_ae(umbral_ae),
        .data_out(data_out), .valid_out(valid_out), .full_fifo(full_fifo), .empty_fifo(empty_fifo),
        .almost_full_fifo(almost_full_fifo), .almost_empty_fifo(almost_empty_fifo),
        .overflow_err(overflow_err), .underflow_err(underflow_err),
        .cnt_out(cnt_out), .peak_cnt(peak_cnt)
    );
    logic [18:0] obs;
    assign obs = {data_out, valid_out, cnt_out, full_fifo, empty_fifo, almost_full_fifo,
                  almost_empty_fifo, overflow_err, underflow_err, peak_cnt};
    function automatic logic [18:0] exp_vec();
        int n = q.size();
        return {m_data, m_valid, 3'(n), n == 4, n == 0, n >= int'(umbral_af), n <= int'(umbral_ae),
                m_ovf, m_udf, 3'(m_peak)};
    endfunction
    task automatic step(input logic rst, input logic ini, input logic w, input logic r, input logic [5:0] d);
        bit ra, wa;
        reset = rst; init = ini; wr_enable = w; rd_enable = r; data_in = d;
        @(posedge clk);
        if (rst || !ini) begin
            q.delete(); m_data = '0; m_valid = 0; m_ovf = 0; m_udf = 0; m_peak = 0;
        end else begin
            ra = r && q.size() > 0;
            wa = w && (q.size() < 4 || ra);
            if (r && q.size() == 0) m_udf = 1;
            if (w && q.size() == 4 && !ra) m_ovf = 1;
            m_valid = ra;
            m_data = ra ? q.pop_front() : 6'h0;
            if (wa) q.push_back(d);
            if (PEAK_EN && q.size() > m_peak) m_peak = q.size();
        end
        #1;
        reset = 0; init = 1; wr_enable = 0; rd_enable = 0; data_in = 0;
    endtask
    task automatic test_reset();
        step(1, 1, 1, 1, 6'h2B);
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_state: got %h want %h", obs, exp_vec()); end
        checks++;
        if ({empty_fifo, full_fifo, cnt_out, valid_out} !== 6'b100000) begin
            errors++; $display("FAIL reset_flags: got %b want 100000", {empty_fifo, full_fifo, cnt_out, valid_out});
        end
    endtask
    task automatic test_order();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 6'h11 + 6'(i));
        checks++;
        if ({full_fifo, cnt_out} !== 4'b1100) begin errors++; $display("FAIL order_full: got %b want 1100", {full_fifo, cnt_out}); end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 0);
            checks++;
            if ({valid_out, data_out} !== {1'b1, 6'h11 + 6'(i)} || obs !== exp_vec()) begin
                errors++; $display("FAIL order_read%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        step(0, 1, 0, 0, 0);
        checks++;
        if ({empty_fifo, valid_out, data_out} !== 8'h80) begin
            errors++; $display("FAIL order_empty: got %h want 80", {empty_fifo, valid_out, data_out});
        end
    endtask
    task automatic test_overflow();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 6'h11 + 6'(i));
        step(0, 1, 1, 0, 6'h3F);
        checks++;
        if ({overflow_err, cnt_out} !== 4'b1100) begin errors++; $display("FAIL ovf_flag: got %b want 1100", {overflow_err, cnt_out}); end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 0);
            checks++;
            if (data_out !== 6'h11 + 6'(i) || obs !== exp_vec()) begin
                errors++; $display("FAIL ovf_read%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    endtask
    task automatic test_underflow();
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 6'h05);
        checks++;
        if ({underflow_err, valid_out, cnt_out} !== 5'b10001) begin
            errors++; $display("FAIL udf_flag: got %b want 10001", {underflow_err, valid_out, cnt_out});
        end
        step(0, 1, 0, 1, 0);
        checks++;
        if ({valid_out, data_out} !== 7'h45 || obs !== exp_vec()) begin
            errors++; $display("FAIL udf_read: got %h want %h", obs, exp_vec());
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({underflow_err, empty_fifo} !== 2'b01) begin errors++; $display("FAIL udf_init_clear: got %b want 01", {underflow_err, empty_fifo}); end
    endtask
    task automatic test_full_rw();
        logic [5:0] want [6] = '{6'h11, 6'h12, 6'h13, 6'h14, 6'h2A, 6'h2A};
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 6'h11 + 6'(i));
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 1, 6'h2A);
            checks++;
            if ({data_out, valid_out, cnt_out, overflow_err} !== {want[i], 1'b1, 3'd4, 1'b0} || obs !== exp_vec()) begin
                errors++; $display("FAIL full_rw%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 0);
            checks++;
            if (data_out !== 6'h2A) begin errors++; $display("FAIL full_rw_drain%0d: got %h want 2a", i, data_out); end
        end
    endtask
    task automatic test_thresholds();
        umbral_af = 3; umbral_ae = 1;
        step(1, 1, 0, 0, 0);
        for (int k = 0; k <= 4; k++) begin
            checks++;
            if ({almost_empty_fifo, almost_full_fifo} !== {k <= 1, k >= 3}) begin
                errors++; $display("FAIL thresh_occ%0d: got %b want %b", k, {almost_empty_fifo, almost_full_fifo}, {k <= 1, k >= 3});
            end
            if (k < 4) step(0, 1, 1, 0, 6'(k));
        end
        umbral_af = 0;
        step(1, 1, 0, 0, 0);
        checks++;
        if ({almost_full_fifo, almost_empty_fifo} !== 2'b11) begin errors++; $display("FAIL thresh_af0: got %b want 11", {almost_full_fifo, almost_empty_fifo}); end
        umbral_af = 3;
    endtask
    task automatic test_peak();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 6'(i));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
        checks++;
        if (peak_cnt !== (PEAK_EN ? 3'd3 : 3'd0)) begin errors++; $display("FAIL peak_val: got %0d want %0d", peak_cnt, PEAK_EN ? 3 : 0); end
        step(1, 1, 1, 0, 6'h09);
        checks++;
        if ({data_out, valid_out, cnt_out, overflow_err, underflow_err, peak_cnt, empty_fifo} !== 17'h1) begin
            errors++; $display("FAIL peak_reset: got %h want 1", {data_out, valid_out, cnt_out, overflow_err, underflow_err, peak_cnt, empty_fifo});
        end
    endtask
    task automatic test_reset_midburst();
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 6'h21);
        step(0, 1, 1, 0, 6'h22);
        step(1, 1, 1, 1, 6'h23);
        step(0, 1, 1, 0, 6'h07);
        step(0, 1, 0, 1, 0);
        checks++;
        if ({valid_out, data_out, cnt_out} !== {1'b1, 6'h07, 3'd0}) begin
            errors++; $display("FAIL midburst: got %h want %h", {valid_out, data_out, cnt_out}, {1'b1, 6'h07, 3'd0});
        end
    endtask
    task automatic test_random();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin umbral_af = 3'($urandom_range(0, 5)); umbral_ae = 3'($urandom_range(0, 5)); end
            step($urandom_range(0, 59) == 0, $urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom), 6'($urandom));
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random%0d: got %h want %h", i, obs, exp_vec()); end
        end
        umbral_af = 3; umbral_ae = 1;
    endtask
    initial begin
        reset = 1; init = 1; wr_enable = 0; rd_enable = 0; data_in = 0;
        umbral_af = 3; umbral_ae = 1;
        q.delete(); m_data = 0; m_valid = 0; m_ovf = 0; m_udf = 0; m_peak = 0;
        #2;
        test_reset();
        test_order();
        test_overflow();
        test_underflow();
        test_full_rw();
        test_thresholds();
        test_peak();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tx_fifo_param.md
TX_FIFO_PARAM -- requirements
Module: tx_fifo_param

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 6 and set the data word width.
REQ-002 Parameter ADDR_WIDTH SHALL default to 2 and set the pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 init  input  1  active-low soft clear; 0 SHALL hold the block in the cleared state.
REQ-006 wr_enable  input  1  write request; rd_enable  input  1  read request.
REQ-007 data_in  input  DATA_WIDTH  write data.
REQ-008 umbral_af  input  ADDR_WIDTH+1  almost-full threshold; umbral_ae  input  ADDR_WIDTH+1  almost-empty threshold.
REQ-009 data_out  output  DATA_WIDTH  registered read data; valid_out  output  1  data_out qualifier.
REQ-010 full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo  output  1 each  status flags.
REQ-011 overflow_err, underflow_err  output  1 each  sticky error flags.
REQ-012 cnt_out  output  ADDR_WIDTH+1  current occupancy; peak_cnt  output  ADDR_WIDTH+1  high-water mark.

Function
REQ-013 A write SHALL be accepted iff wr_enable=1 and (full_fifo=0 or a read is accepted in the same cycle); accepted write stores data_in at wr_ptr, wr_ptr increments.
REQ-014 A read SHALL be accepted iff rd_enable=1 and empty_fifo=0; accepted read increments rd_ptr.
REQ-015 Read latency SHALL be one cycle: the edge accepting a read loads data_out=mem[rd_ptr] and valid_out=1.
REQ-016 In any cycle with no accepted read, data_out SHALL be 0 and valid_out 0 after the edge.
REQ-017 Pointers SHALL wrap modulo DEPTH without extra logic or bubbles.
REQ-018 Occupancy SHALL be +1 on accepted write only, -1 on accepted read only, unchanged on both or neither; never outside 0..DEPTH.
REQ-019 full_fifo=(cnt==DEPTH); empty_fifo=(cnt==0); almost_full_fifo=(cnt>=umbral_af); almost_empty_fifo=(cnt<=umbral_ae); all combinational from the registered count.
REQ-020 Write on full with no accepted read SHALL be dropped (memory, wr_ptr, count unchanged) and set overflow_err.
REQ-021 Read on empty SHALL be ignored (rd_ptr unchanged, valid_out 0) and set underflow_err, including when a write is accepted the same cycle.
REQ-022 Simultaneous write+read on full SHALL accept both; count stays DEPTH, oldest word is output.
REQ-023 overflow_err and underflow_err SHALL remain set until reset=1 or init=0.
REQ-024 cnt_out SHALL equal the registered occupancy.

Reset
REQ-025 On a rising edge with reset=1 or init=0: pointers, count, data_out, valid_out, errors, peak_cnt SHALL clear to 0 and all memory words to 0.
REQ-026 After clear: empty_fifo=1, full_fifo=0, almost_empty_fifo=(umbral_ae>=0)=1, almost_full_fifo=(umbral_af==0).
REQ-027 reset SHALL take priority over all traffic; wr/rd requests in a reset cycle SHALL be discarded.
REQ-028 Reset asserted mid-burst SHALL discard all stored data; first write after release lands at address 0.

Configuration
REQ-029 Macro FIFO_PEAK_TRACK_EN defined: peak_cnt SHALL register max(peak_cnt, next occupancy) every edge, cleared by reset/init.
REQ-030 Macro FIFO_PEAK_TRACK_EN undefined: peak_cnt SHALL be constant 0 and no tracking register SHALL be synthesised.

Verification (DATA_WIDTH=6, ADDR_WIDTH=2, DEPTH=4)
REQ-031 Write 0x11,0x12,0x13,0x14 then read 4 -> data_out 0x11..0x14 each one cycle after read, valid_out=1, full then empty asserted.
REQ-032 Fill to 4, write 0x3F without read -> overflow_err=1, cnt_out=4, later reads return 0x11..0x14 only.
REQ-033 Empty FIFO, rd_enable=1 with wr_enable=1 data 0x05 -> underflow_err=1, valid_out=0, cnt_out=1; next read returns 0x05.
REQ-034 Full FIFO, simultaneous write 0x2A + read -> cnt_out stays 4, data_out=oldest word, no overflow_err; six such cycles exercise pointer wrap.
REQ-035 umbral_af=3, umbral_ae=1: occupancy 0..4 -> almost_empty at 0,1; almost_full at 3,4.
REQ-036 With FIFO_PEAK_TRACK_EN: fill 3, drain 3 -> peak_cnt=3; reset=1 one cycle -> all outputs 0, empty_fifo=1; without macro peak_cnt=0 throughout.
